// File: rtl/mfc_mem_responder.sv
// mfc_mem_responder: multi-cycle memory responder for the WMFC/rnw/MFC handshake.
// Define RESP_ERR_EN to guard addresses >= LIMIT (suppressed writes, all-ones reads, err pulse).
module mfc_mem_responder #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int LAT   = 3,
    parameter int LIMIT = 240
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          enable,
    input  logic          rnw,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          MFC,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;
    state_t        state;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] a_q;
    logic          rnw_q;
    logic [DW-1:0] d_q;
    logic [3:0]    cnt;
    logic          last;
    logic          bad;
    logic          wr_en;

    if (LAT < 1 || LAT > 15 || LIMIT < 0 || LIMIT > 2**AW) begin : g_bad_cfg
        $error("mfc_mem_responder: LAT must be 1..15 and LIMIT within the address space");
    end

    assign last = state == WAIT && cnt == 4'(LAT - 1);
`ifdef RESP_ERR_EN
    assign bad = int'(a_q) >= LIMIT;
`else
    assign bad = 1'b0;
`endif
    assign wr_en = last && !rnw_q && !bad;

    // The array is deliberately outside the reset domain: reset must not clear contents.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[a_q] <= d_q;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            MFC   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            a_q   <= '0;
            rnw_q <= 1'b0;
            d_q   <= '0;
        end else begin
            MFC <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    a_q   <= addr;
                    rnw_q <= rnw;
                    d_q   <= wdata;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= WAIT;
                end
                WAIT: if (last) begin
                    if (rnw_q) rdata <= bad ? '1 : mem[a_q];
                    MFC   <= 1'b1;
                    busy  <= 1'b0;
                    err   <= bad;
                    state <= DONE;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                // A level-held strobe parks in HOLD so it cannot retrigger.
                DONE: state <= enable ? HOLD : IDLE;
                HOLD: state <= enable ? HOLD : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mfc_mem_responder.sv
// tb_mfc_mem_responder: vector table, directed corner sequences and random traffic
// checked against a transaction-level model of the responder.
module tb_mfc_mem_responder;
    localparam int LAT   = 3;
    localparam int LIMIT = 240;
`ifdef RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0, en1 = 1'b0, en15 = 1'b0;
    logic       rnw = 1'b1;
    logic [7:0] addr = '0, wdata = '0;
    logic [7:0] rdata, rdata1, rdata15;
    logic       MFC, busy, err, m1, m15, b1, b15, e1, e15;

    int checks = 0;
    int errors = 0;
    bit mdl_on = 1'b0;

    mfc_mem_responder #(.DW(8), .AW(8), .LAT(LAT), .LIMIT(LIMIT)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .rnw(rnw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .MFC(MFC), .busy(busy), .err(err));
    mfc_mem_responder #(.DW(8), .AW(8), .LAT(1), .LIMIT(LIMIT)) dut1 (
        .CLK(CLK), .reset(reset), .enable(en1), .rnw(rnw), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .MFC(m1), .busy(b1), .err(e1));
    mfc_mem_responder #(.DW(8), .AW(8), .LAT(15), .LIMIT(LIMIT)) dut15 (
        .CLK(CLK), .reset(reset), .enable(en15), .rnw(rnw), .addr(addr), .wdata(wdata),
        .rdata(rdata15), .MFC(m15), .busy(b15), .err(e15));

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request is accepted when the responder is free and the strobe
    // has been seen low since the previous completion; it completes LAT edges later.
    bit [7:0] mem_m [256];
    bit       infl, mr, need_low;
    bit [7:0] ma, md;
    int       edge_n, acc_e, done_e;
    bit       e_mfc, e_busy, e_err;
    bit [7:0] e_rdata;

    initial begin
        bit bad;
        forever begin
            @(posedge CLK or posedge reset);
            if (reset) begin
                infl = 0; need_low = 0; done_e = -10;
                e_mfc = 0; e_busy = 0; e_err = 0; e_rdata = 8'h00;
            end else begin
                e_mfc = 0; e_err = 0;
                if (infl) begin
                    if (edge_n == acc_e + LAT) begin
                        infl = 0; e_mfc = 1; e_busy = 0; done_e = edge_n; need_low = 1;
                        bad = ERR_EN && int'(ma) >= LIMIT;
                        e_err = bad;
                        if (mr) e_rdata = bad ? 8'hFF : mem_m[ma];
                        else if (!bad) mem_m[ma] = md;
                    end
                end else if (edge_n == done_e + 1 || need_low) begin
                    if (!enable) need_low = 0;
                end else if (enable) begin
                    infl = 1; acc_e = edge_n; ma = addr; md = wdata; mr = rnw; e_busy = 1;
                end
            end
            edge_n++;
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (mdl_on) begin
                check("model_mfc", MFC, e_mfc);
                check("model_busy", busy, e_busy);
                check("model_err", err, e_err);
                check("model_rdata", rdata, e_rdata);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Called at posedge+1: asserts reset mid-cycle and checks the asynchronous clear.
    task automatic reset_pulse(input string nm);
        #2 reset = 1'b1;
        enable = 1'b0;
        #1;
        check({nm, "_mfc"}, MFC, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_err"}, err, 0);
        check({nm, "_rdata"}, rdata, 0);
        #2 reset = 1'b0;
    endtask

    task automatic xact(input bit r, input bit [7:0] a, input bit [7:0] d,
                        output bit [7:0] rd, output bit er);
        int n = 0;
        rnw = r; addr = a; wdata = d; enable = 1'b1;
        do begin
            cyc();
            n++;
        end while (!MFC && n < 40);
        check("latency_edges", n, LAT + 1);
        rd = rdata;
        er = err;
        enable = 1'b0;
        cyc();
        check("mfc_one_cycle", MFC, 0);
    endtask

    typedef struct {
        bit       en;
        bit       r;
        bit [7:0] a;
        bit [7:0] d;
        bit       mfc;
        bit       bsy;
        bit [7:0] rd;
    } vec_t;
    vec_t tbl[$];

    task automatic row(input bit en, input bit r, input bit [7:0] a, input bit [7:0] d,
                       input bit mfc, input bit bsy, input bit [7:0] rd);
        vec_t v;
        v.en = en; v.r = r; v.a = a; v.d = d; v.mfc = mfc; v.bsy = bsy; v.rd = rd;
        tbl.push_back(v);
    endtask

    initial begin
        bit [7:0] rd;
        bit       er;
        int       p, p1, p15, t1, t15, bc1, bc15;
        repeat (3) cyc();
        reset = 1'b0;
        mdl_on = 1'b1;
        cyc();

        // Latency bounds on the LAT=1 and LAT=15 instances with a level-held strobe.
        rnw = 1'b1; addr = 8'h00; en1 = 1'b1; en15 = 1'b1;
        p1 = 0; p15 = 0; t1 = 0; t15 = 0; bc1 = 0; bc15 = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (m1) begin p1++; t1 = i; end
            if (m15) begin p15++; t15 = i; end
            bc1 += int'(b1);
            bc15 += int'(b15);
        end
        check("lat1_mfc_edge", t1, 2);
        check("lat1_pulses", p1, 1);
        check("lat1_busy_cycles", bc1, 1);
        check("lat15_mfc_edge", t15, 16);
        check("lat15_pulses", p15, 1);
        check("lat15_busy_cycles", bc15, 15);
        en1 = 1'b0; en15 = 1'b0;
        cyc();

        for (int a = 0; a < 256; a++) xact(1'b0, 8'(a), 8'(a) ^ 8'h5A, rd, er);
        xact(1'b0, 8'h10, 8'h00, rd, er);
        xact(1'b0, 8'h30, 8'h3C, rd, er);

        // Write A5 to 22, read it back, then show a held strobe is not re-accepted.
        row(1, 0, 8'h22, 8'hA5, 0, 1, 8'h00);
        row(0, 0, 8'h00, 8'h00, 0, 1, 8'h00);
        row(0, 0, 8'h00, 8'h00, 0, 1, 8'h00);
        row(0, 0, 8'h00, 8'h00, 1, 0, 8'h00);
        row(0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        row(1, 1, 8'h22, 8'h00, 0, 1, 8'h00);
        row(1, 1, 8'h22, 8'h00, 0, 1, 8'h00);
        row(1, 1, 8'h22, 8'h00, 0, 1, 8'h00);
        row(1, 1, 8'h22, 8'h00, 1, 0, 8'hA5);
        row(1, 1, 8'h22, 8'h00, 0, 0, 8'hA5);
        row(1, 1, 8'h22, 8'h00, 0, 0, 8'hA5);
        row(0, 1, 8'h22, 8'h00, 0, 0, 8'hA5);
        row(1, 1, 8'h22, 8'h00, 0, 1, 8'hA5);
        row(0, 1, 8'h00, 8'h00, 0, 1, 8'hA5);
        row(0, 1, 8'h00, 8'h00, 0, 1, 8'hA5);
        row(0, 1, 8'h00, 8'h00, 1, 0, 8'hA5);
        row(0, 1, 8'h00, 8'h00, 0, 0, 8'hA5);
        reset_pulse("rst_idle");
        foreach (tbl[i]) begin
            enable = tbl[i].en; rnw = tbl[i].r; addr = tbl[i].a; wdata = tbl[i].d;
            cyc();
            check($sformatf("tbl%0d_mfc", i), MFC, tbl[i].mfc);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
        end

        // Reset in WAIT on the edge before a write to 10 would commit.
        enable = 1'b1; rnw = 1'b0; addr = 8'h10; wdata = 8'h99;
        cyc(); cyc(); enable = 1'b0; cyc();
        reset_pulse("rst_wait");
        xact(1'b1, 8'h10, 8'h00, rd, er);
        check("rst_wait_no_commit", rd, 8'h00);

        // Reset in DONE and in HOLD.
        enable = 1'b1; rnw = 1'b1; addr = 8'h22;
        p = 0;
        do begin cyc(); p++; end while (!MFC && p < 40);
        reset_pulse("rst_done");
        cyc();
        enable = 1'b1;
        p = 0;
        do begin cyc(); p++; end while (!MFC && p < 40);
        cyc();
        reset_pulse("rst_hold");
        cyc();

        // Level-held enable yields a single MFC until the strobe drops.
        enable = 1'b1; rnw = 1'b1; addr = 8'h05;
        p = 0;
        for (int i = 0; i < 10; i++) begin cyc(); p += int'(MFC); end
        check("held_pulses", p, 1);
        check("held_busy", busy, 0);
        enable = 1'b0; cyc(); enable = 1'b1;
        p = 0;
        for (int i = 0; i < 8; i++) begin cyc(); p += int'(MFC); end
        check("rearm_pulses", p, 1);
        check("rearm_rdata", rdata, 8'h05 ^ 8'h5A);
        enable = 1'b0; cyc(); cyc();

        // Inputs changing during WAIT are ignored.
        enable = 1'b1; rnw = 1'b1; addr = 8'h30;
        cyc();
        addr = 8'h31; rnw = 1'b0; wdata = 8'hEE; enable = 1'b0;
        p = 0;
        do begin cyc(); p++; end while (!MFC && p < 40);
        check("midchg_mfc", MFC, 1);
        check("midchg_rdata", rdata, 8'h3C);
        cyc();
        xact(1'b1, 8'h31, 8'h00, rd, er);
        check("midchg_no_write", rd, 8'h31 ^ 8'h5A);

        // Protected range behaviour (err and data depend on RESP_ERR_EN).
        xact(1'b0, 8'hF5, 8'h77, rd, er);
        check("err_write_flag", er, ERR_EN);
        xact(1'b1, 8'hF5, 8'h00, rd, er);
        check("err_read_flag", er, ERR_EN);
        check("err_read_data", rd, ERR_EN ? 8'hFF : 8'h77);
        xact(1'b1, 8'hEF, 8'h00, rd, er);
        check("below_limit_flag", er, 0);
        check("below_limit_data", rd, 8'hEF ^ 8'h5A);

        // Random traffic with occasional resets, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            enable = $urandom_range(0, 3) != 0;
            rnw = 1'($urandom);
            addr = $urandom_range(0, 1) != 0 ? 8'($urandom_range(0, 15)) : 8'($urandom);
            wdata = 8'($urandom);
            reset = $urandom_range(0, 299) == 0;
            cyc();
        end
        reset = 1'b0; enable = 1'b0;
        repeat (20) cyc();
        xact(1'b1, 8'h22, 8'h00, rd, er);
        check("final_read", rd, ERR_EN && 8'h22 >= 8'(LIMIT) ? 8'hFF : mem_m[8'h22]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mfc_mem_responder.md
Name: mfc_mem_responder

Overview:
- Memory-side responder for the processor's WMFC / rnw / MFC memory handshake. Used as the counterpart to the control-unit initiator.
- Accepts one read or write request per handshake and holds the address, direction and write data internally.
- Models a fixed access latency with a wait-state counter, then returns read data and a one-cycle MFC (memory function complete) pulse.
- Sits between the MAR/bus data path and the MBR input. It is a multi-cycle alternative to the single-cycle RAM model.

Parameters:
- DW, 8, data width (bus / MBR width)
- AW, 8, address width; array depth is 2^AW words
- LAT, 3, wait states from request acceptance to MFC; legal range 1..15
- LIMIT, 240, first protected address (used only when RESP_ERR_EN is defined)

Ports:
- CLK  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  request strobe (WMFC control signal), level-sensitive
- rnw  input  1  1 = read, 0 = write; sampled at acceptance
- addr  input  AW  address (MAR value); sampled at acceptance
- wdata  input  DW  write data from bus; sampled at acceptance
- rdata  output  DW  read data toward MBR; valid from the MFC cycle onward
- MFC  output  1  one-cycle completion pulse
- busy  output  1  high while a request is in flight (WAIT state)
- err  output  1  error flag, pulses with MFC (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, MFC=0, busy=0, err=0, rdata=0, latched request cleared. Memory array is not cleared.
- Reset during WAIT aborts the transaction; a pending write is never committed.
- Internal storage: 2^AW x DW array; latched regs a_q, rnw_q, d_q; counter cnt of 4 bits.
- State IDLE:
  - enable=1 at an edge: latch addr/rnw/wdata, set cnt=0, go to WAIT, busy<=1.
  - enable=0: stay in IDLE.
- State WAIT:
  - Each edge with cnt != LAT-1: cnt<=cnt+1.
  - Edge with cnt == LAT-1: perform the access and go to DONE.
    - Read: rdata<=mem[a_q].
    - Write: mem[a_q]<=d_q; rdata unchanged.
    - MFC<=1, busy<=0.
  - enable and input changes during WAIT are ignored. A transaction is committed once accepted.
- State DONE (MFC=1 for exactly this one cycle), at the next edge: MFC<=0.
  - enable=1: go to HOLD.
  - enable=0: go to IDLE.
- State HOLD: wait for enable=0, then go to IDLE. No new request is accepted until enable has been seen low. This prevents a level-held WMFC from retriggering.
- Latency: request accepted at edge k, so MFC is high in the cycle after edge k+LAT. With LAT=3 the access takes 4 cycles, counted from the enable sample to the end of the MFC cycle.
- Back-to-back requests: the minimum spacing is acceptance, LAT cycles, the DONE cycle, then one cycle with enable low.
- rdata holds its last read value until the next read completes or reset occurs.
- Read-after-write to the same address returns the newly written data, because the write commits at the DONE transition.
- err=0 whenever the feature is compiled out.

Optional Feature:
- Macro: RESP_ERR_EN.
- Defined:
  - Any request with a_q >= LIMIT completes with normal latency and normal MFC timing.
  - A write to such an address is suppressed.
  - A read to such an address loads rdata with all ones.
  - err=1 in the MFC cycle only.
- Undefined: every address is valid, LIMIT is unused, and err is tied to 0.

Test Plan:
- Reset checks: assert reset mid-clock in every state, including WAIT on a write to 8'h10 holding 8'h00. Require MFC/busy/err/rdata=0 immediately, and mem[8'h10] still 8'h00 afterwards.
- Write then read: with LAT=3, write 8'hA5 to 8'h22, then read 8'h22.
  - Each MFC appears exactly 3 edges after acceptance and lasts 1 cycle.
  - rdata=8'hA5 in the read's MFC cycle.
  - busy is high for 3 cycles per access.
- Level-held enable: hold enable=1 for 10 cycles on a read of 8'h05. Require exactly one MFC pulse and the state held in HOLD; after enable drops and rises again, a second MFC is produced.
- Input changes mid-access: during WAIT on a read of 8'h30 (containing 8'h3C), change addr to 8'h31, flip rnw to 0 and drop enable. Require rdata=8'h3C, no write to 8'h31, and MFC still delivered.
- Error path (RESP_ERR_EN, LIMIT=240):
  - Write 8'h77 to 8'hF5: err=1 with MFC, and a subsequent read of 8'hF5 gives rdata=8'hFF with err=1.
  - Read of 8'hEF: err=0.
- Latency bounds: run with LAT=1 and LAT=15. MFC must arrive 1 and 15 edges after acceptance respectively, with no counter wrap.
